// File: rtl/imm_encoder.sv
// imm_encoder: packs a signed 32-bit immediate into the RV32 bit positions
// of the selected instruction format (I/B/U/S/J) and merges it into a base
// instruction word. Two-stage valid/ready pipeline with a saturating count
// of emitted error results.
//
// Build option: define IMM_ENC_RANGECHK_EN to flag out-of-range and
// misaligned immediates on out_err. Without it, only illegal formats
// (5-7) raise out_err. Immediates that do not fit are always truncated.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_B = 3'd1;
  localparam logic [2:0] FMT_U = 3'd2;
  localparam logic [2:0] FMT_S = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_instr_q, s1_instr_d;
  logic             s1_err_q,   s1_err_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_instr_q, s2_instr_d;
  logic             s2_err_q,   s2_err_d;
  logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;

  logic [31:0] enc_instr;
  logic        enc_err;
  logic        s1_adv;
  logic        s2_adv;

`ifdef IMM_ENC_RANGECHK_EN
  // An immediate fits a field of width N when all bits above the field's
  // sign bit replicate it.
  logic hi11_same;
  logic hi12_same;
  logic hi20_same;
  assign hi11_same = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign hi12_same = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign hi20_same = (&in_imm[31:20]) | ~(|in_imm[31:20]);
`endif

  // Scatter the immediate into the format's bit positions; keep the rest of base.
  always_comb begin
    enc_instr = in_base;
    enc_err   = 1'b0;
    case (in_fmt)
      FMT_I: begin
        enc_instr = {in_imm[11:0], in_base[19:0]};
`ifdef IMM_ENC_RANGECHK_EN
        enc_err = ~hi11_same;
`endif
      end
      FMT_B: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_base[24:12],
                     in_imm[4:1], in_imm[11], in_base[6:0]};
`ifdef IMM_ENC_RANGECHK_EN
        enc_err = ~hi12_same | in_imm[0];
`endif
      end
      FMT_U: begin
        enc_instr = {in_imm[31:12], in_base[11:0]};
`ifdef IMM_ENC_RANGECHK_EN
        enc_err = |in_imm[11:0];
`endif
      end
      FMT_S: begin
        enc_instr = {in_imm[11:5], in_base[24:12], in_imm[4:0], in_base[6:0]};
`ifdef IMM_ENC_RANGECHK_EN
        enc_err = ~hi11_same;
`endif
      end
      FMT_J: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                     in_base[11:0]};
`ifdef IMM_ENC_RANGECHK_EN
        enc_err = ~hi20_same | in_imm[0];
`endif
      end
      default: begin
        // Unknown format: pass the base word through untouched and flag it.
        enc_instr = in_base;
        enc_err   = 1'b1;
      end
    endcase
  end

  // Stage advance conditions; S1 can refill in the same cycle S2 drains.
  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = ~reset & s1_adv;

  // Next-state for both pipeline stages and the saturating error counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_instr_d = s1_instr_q;
    s1_err_d   = s1_err_q;
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    err_cnt_d  = err_cnt_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_instr_d = enc_instr;
        s1_err_d   = enc_err;
      end
    end

    // S2 data only changes when it advances, so outputs hold while stalled.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_d = s1_instr_q;
        s2_err_d   = s1_err_q;
      end
    end

    if (s2_valid_q && out_ready && s2_err_q && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // State registers; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_instr_q <= s1_instr_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed testbench for imm_encoder. Uses a narrow error counter so that
// saturation is reachable in a short run.
module tb_imm_encoder;

`ifdef IMM_ENC_RANGECHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_fmt;
  logic [31:0]   in_imm;
  logic [31:0]   in_base;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic          out_err;
  logic [CW-1:0] err_count;

  int vectors = 0;
  int miscompares = 0;
  logic [CW-1:0] exp_cnt = '0;

  imm_encoder #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_imm(in_imm), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference decoders (the extractor direction) for round-trip checks.
  function automatic logic [31:0] extract_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] extract_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  task automatic note_err(input logic e);
    if (e && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
  endtask

  // Drives one transaction with out_ready=1 and returns what came out.
  task automatic xact(input logic [2:0] f, input logic [31:0] imm, input logic [31:0] base,
                      output logic [31:0] instr, output logic err, output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_fmt = f; in_imm = imm; in_base = base; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    instr = out_instr;
    err = out_err;
    @(negedge clk);
    $display("xact fmt=%0d imm=%08h base=%08h -> instr=%08h err=%0b lat=%0d cnt=%0d",
             f, imm, base, instr, err, lat, err_count);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_fmt = 3'd7; in_imm = 32'h1; in_base = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    vectors++; if (out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_out_instr got=%08h exp=00000000", out_instr); end
    vectors++; if (out_err !== 1'b0) begin miscompares++; $display("FAIL reset_out_err got=%0b exp=0", out_err); end
    vectors++; if (err_count !== '0) begin miscompares++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    reset = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_input_ignored got=%0b exp=0", out_valid); end
  endtask

  task automatic test_i_format();
    logic [31:0] r; logic e; int lat;
    xact(3'd0, 32'hFFFF_F800, 32'h0000_0013, r, e, lat);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL i_latency got=%0d exp=2", lat); end
    vectors++; if (r !== 32'h8000_0013) begin miscompares++; $display("FAIL i_min_instr got=%08h exp=80000013", r); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL i_min_err got=%0b exp=0", e); end
    xact(3'd0, 32'h0000_0800, 32'h0000_0013, r, e, lat);
    note_err(CHK);
    vectors++; if (r !== 32'h8000_0013) begin miscompares++; $display("FAIL i_ovf_instr got=%08h exp=80000013", r); end
    vectors++; if (e !== CHK) begin miscompares++; $display("FAIL i_ovf_err got=%0b exp=%0b", e, CHK); end
  endtask

  task automatic test_b_format();
    logic [31:0] r; logic e; int lat;
    xact(3'd1, 32'h0000_0FFE, 32'h0000_0063, r, e, lat);
    vectors++; if (r !== 32'h7E00_0FE3) begin miscompares++; $display("FAIL b_max_instr got=%08h exp=7E000FE3", r); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL b_max_err got=%0b exp=0", e); end
    vectors++; if (extract_b(r) !== 32'h0000_0FFE) begin miscompares++; $display("FAIL b_roundtrip got=%08h exp=00000FFE", extract_b(r)); end
    xact(3'd1, 32'h0000_0003, 32'h0000_0063, r, e, lat);
    note_err(CHK);
    vectors++; if (r !== 32'h0000_0163) begin miscompares++; $display("FAIL b_odd_instr got=%08h exp=00000163", r); end
    vectors++; if (e !== CHK) begin miscompares++; $display("FAIL b_odd_err got=%0b exp=%0b", e, CHK); end
    vectors++; if (err_count !== exp_cnt) begin miscompares++; $display("FAIL b_err_count got=%0d exp=%0d", err_count, exp_cnt); end
  endtask

  task automatic test_u_format();
    logic [31:0] r; logic e; int lat;
    logic [CW-1:0] base_cnt;
    base_cnt = exp_cnt;
    xact(3'd2, 32'h1234_5000, 32'h0000_0537, r, e, lat);
    vectors++; if (r !== 32'h1234_5537) begin miscompares++; $display("FAIL u_ok_instr got=%08h exp=12345537", r); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL u_ok_err got=%0b exp=0", e); end
    xact(3'd2, 32'h1234_5678, 32'h0000_0537, r, e, lat);
    note_err(CHK);
    vectors++; if (r !== 32'h1234_5537) begin miscompares++; $display("FAIL u_low_instr got=%08h exp=12345537", r); end
    vectors++; if (e !== CHK) begin miscompares++; $display("FAIL u_low_err got=%0b exp=%0b", e, CHK); end
    vectors++; if (err_count !== base_cnt + CW'(CHK)) begin miscompares++; $display("FAIL u_err_count got=%0d exp=%0d", err_count, base_cnt + CW'(CHK)); end
  endtask

  task automatic test_s_format();
    logic [31:0] r; logic e; int lat;
    xact(3'd3, 32'hFFFF_FFF8, 32'h0000_2023, r, e, lat);
    vectors++; if (r !== 32'hFE00_2C23) begin miscompares++; $display("FAIL s_neg_instr got=%08h exp=FE002C23", r); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL s_neg_err got=%0b exp=0", e); end
    xact(3'd3, 32'h0000_0800, 32'h0000_2023, r, e, lat);
    note_err(CHK);
    vectors++; if (r !== 32'h8000_2023) begin miscompares++; $display("FAIL s_ovf_instr got=%08h exp=80002023", r); end
    vectors++; if (e !== CHK) begin miscompares++; $display("FAIL s_ovf_err got=%0b exp=%0b", e, CHK); end
  endtask

  task automatic test_j_and_illegal();
    logic [31:0] r; logic e; int lat;
    xact(3'd4, 32'hFFFF_FFFE, 32'h0000_006F, r, e, lat);
    vectors++; if (r !== 32'hFFFF_F06F) begin miscompares++; $display("FAIL j_neg_instr got=%08h exp=FFFFF06F", r); end
    vectors++; if (extract_j(r) !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL j_roundtrip got=%08h exp=FFFFFFFE", extract_j(r)); end
    xact(3'd4, 32'h0000_0001, 32'h0000_006F, r, e, lat);
    note_err(CHK);
    vectors++; if (r !== 32'h0000_006F) begin miscompares++; $display("FAIL j_odd_instr got=%08h exp=0000006F", r); end
    vectors++; if (e !== CHK) begin miscompares++; $display("FAIL j_odd_err got=%0b exp=%0b", e, CHK); end
    xact(3'd6, 32'h0000_0123, 32'hCAFE_F00D, r, e, lat);
    note_err(1'b1);
    vectors++; if (r !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL illegal_instr got=%08h exp=CAFEF00D", r); end
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL illegal_err got=%0b exp=1", e); end
    vectors++; if (err_count !== exp_cnt) begin miscompares++; $display("FAIL illegal_err_count got=%0d exp=%0d", err_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [8];
    logic [31:0] held;
    int ngot, idx, stall_bad;
    ngot = 0; idx = 0; stall_bad = 0; held = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      if (idx < 4) begin
        in_valid = 1'b1; in_fmt = 3'd0; in_imm = 32'(idx + 1); in_base = 32'h0000_0013;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 2) begin
        held = out_instr;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_stalled got=%0b exp=1", out_valid); end
      end
      if (c > 2 && c < 5 && (out_instr !== held || out_valid !== 1'b1)) stall_bad++;
      if (c == 4) begin
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
        vectors++; if (idx !== 2) begin miscompares++; $display("FAIL bp_accepted got=%0d exp=2", idx); end
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        if (ngot < 8) got[ngot] = out_instr;
        $display("bp out #%0d instr=%08h", ngot, out_instr);
        ngot++;
      end
    end
    in_valid = 1'b0;
    vectors++; if (stall_bad !== 0) begin miscompares++; $display("FAIL bp_stable got=%0d changes exp=0", stall_bad); end
    vectors++; if (ngot !== 4) begin miscompares++; $display("FAIL bp_count got=%0d exp=4", ngot); end
    for (int k = 0; k < 4 && k < ngot; k++) begin
      vectors++;
      if (got[k] !== ((32'(k + 1) << 20) | 32'h13)) begin
        miscompares++;
        $display("FAIL bp_order[%0d] got=%08h exp=%08h", k, got[k], (32'(k + 1) << 20) | 32'h13);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_fmt = 3'd7; in_imm = 32'h0; in_base = 32'h1111_1111;
    @(negedge clk);
    in_base = 32'h2222_2222;
    @(negedge clk);
    in_base = 32'h3333_3333; reset = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid got=%0b exp=0", out_valid); end
    vectors++; if (err_count !== '0) begin miscompares++; $display("FAIL rst_mid_count got=%0d exp=0", err_count); end
    exp_cnt = '0;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rst_mid_dropped got=%0d outputs exp=0", seen); end
  endtask

  task automatic test_saturation();
    logic [31:0] r; logic e; int lat;
    for (int k = 0; k < 9; k++) begin
      xact(3'd5, 32'(k), 32'hA5A5_0000, r, e, lat);
      note_err(1'b1);
      if (k == 2) begin
        vectors++; if (err_count !== 3'd3) begin miscompares++; $display("FAIL sat_count3 got=%0d exp=3", err_count); end
      end
    end
    vectors++; if (err_count !== 3'd7) begin miscompares++; $display("FAIL sat_hold got=%0d exp=7", err_count); end
    vectors++; if (exp_cnt !== err_count) begin miscompares++; $display("FAIL sat_model got=%0d exp=%0d", err_count, exp_cnt); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_fmt = '0; in_imm = '0; in_base = '0; out_ready = 1'b0;
    test_reset();
    test_i_format();
    test_b_format();
    test_u_format();
    test_s_format();
    test_j_and_illegal();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
